aes_mix_columns_serial: RTL and testbench
=========================================

// Module: aes_mix_columns_serial
// PURPOSE
//  Byte-serial AES MixColumns / InvMixColumns engine with valid/ready handshakes.
//  - Accepts one state byte per cycle and accumulates the GF(2^8) products for a
//    4-byte column.
//  - Emits the finished 32-bit column behind an output register with backpressure.
//  - Sits between ShiftRows and AddRoundKey in the byte-serial AES datapath.
//  - Also supports inverse mode for decryption and a bypass mode for the final round.
// PARAMETERS
//  INV_EN     1  1: mode_inv honoured (adds 0e/0b/0d/09 multipliers); 0: mode_inv ignored, forward only
//  BYPASS_EN  1  1: bypass honoured (column passed unmixed); 0: bypass ignored
//  TAG_W      2  width of sideband tag carried from last input byte to output column
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      in_byte valid
//  in_ready   out  1      block accepts in_byte this cycle
//  in_byte    in   8      column byte a_i, i = 0..3 in arrival order
//  in_tag     in   TAG_W  tag, sampled with the 4th byte of a column
//  mode_inv   in   1      1 = InvMixColumns, sampled with 1st byte of a column
//  bypass     in   1      1 = no mixing, sampled with 1st byte of a column
//  out_valid  out  1      out_col valid
//  out_ready  in   1      consumer accepts out_col
//  out_col    out  32     {b0,b1,b2,b3}, b0 in [31:24]
//  out_tag    out  TAG_W  tag of this column
// BEHAVIOUR
//  - Reset values: byte counter = 0, accumulators = 0, out_valid = 0, out_col = 0,
//    out_tag = 0, latched mode = fwd.
//  - in_ready is high after reset.
//  - Handshake:
//    - A byte is accepted when in_valid & in_ready.
//    - An output transfer occurs when out_valid & out_ready.
//    - out_col and out_tag are held stable while out_valid & !out_ready.
//  - Arithmetic:
//    - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 8'h00).
//    - Forward coefficient matrix rows: (02 03 01 01), (01 02 03 01), (01 01 02 03), (03 01 01 02).
//    - Inverse coefficient matrix rows: (0e 0b 0d 09) rotated the same way.
//    - All addition is XOR, 8-bit, with no carries.
//  - Accumulation, on accepting byte a_i with counter = i:
//    - acc_j <= (i==0 ? 0 : acc_j) ^ M[j][i]*a_i, for j = 0..3.
//    - When bypass is latched, acc_j collects a_i at j==i.
//    - Counter increments and wraps 3 -> 0.
//    - Latched mode/bypass update only when i==0.
//  - Completion, on accepting the 4th byte (i==3):
//    - The final acc values, including the 4th-byte product, are loaded into out_col
//      and in_tag into out_tag.
//    - out_valid rises the next cycle; latency from 4th-byte accept to out_valid is 1 cycle.
//  - Backpressure:
//    - in_ready = !(counter==3 && out_valid && !out_ready).
//    - Bytes 0..2 of the next column are accepted while the output stalls.
//    - Only the 4th byte waits.
//    - When out_ready is high, full throughput is 1 byte/cycle, i.e. 1 column per 4 cycles,
//      with no bubbles.
//  - Simultaneous output drain and 4th-byte accept: the new column loads and out_valid
//    stays 1.
//  - Drain without a new column: out_valid falls next cycle.
//  - Mode pins are ignored for bytes 1..3; changing them mid-column has no effect.
//  - Reset mid-column discards the partial column and any pending output; the counter
//    restarts at 0.
// STRUCTURE
//  - aes_pkg:
//    - xtime function
//    - gf_mul function for constants 01/02/03/09/0b/0d/0e
//    - MC_FWD and MC_INV 4x4 coefficient localparam arrays
//    - typedef aes_col_t = logic [3:0][7:0]
//  - One sub-module, aes_gf_col_mul (combinational):
//    - in: byte, column index i, inv.
//    - out: four products M[j][i]*byte.
//  - Remaining top-level logic: counter, mode latch, accumulators, output register,
//    ready logic.
// TESTING
//  1. FIPS-197 forward: bytes d4 bf 5d 30, no stall -> out_col 04_66_81_e5,
//     out_valid 1 cycle after 4th byte.
//  2. Forward db 13 53 45 -> 8e_4d_a1_bc.
//     Then mode_inv=1 on 8e 4d a1 bc -> db_13_53_45.
//  3. Back-to-back columns f2 0a 22 5c, then c6 c6 c6 c6, out_ready=1 ->
//     9f_dc_58_9d, then c6_c6_c6_c6, with no in_ready drop.
//  4. out_ready=0 with one column pending:
//     - next bytes 1..3 are accepted;
//     - in_ready=0 at the 4th byte;
//     - out_col is stable;
//     - raising out_ready -> drain and load happen in the same cycle.
//  5. bypass=1 on 01 02 03 04 -> 01_02_03_04, with out_tag = in_tag of the 4th byte.
//  6. Assert rst after byte 2:
//     - all outputs are 0 the same cycle;
//     - subsequent column d4 bf 5d 30 -> 04_66_81_e5.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers and MixColumns coefficient tables for the
// byte-serial AES datapath.
package aes_pkg;

    typedef logic [3:0][7:0] aes_col_t;

    // Row j, column i holds the multiplier applied to input byte a_i for output byte b_j.
    localparam logic [7:0] MC_FWD [4][4] = '{
        '{8'h02, 8'h03, 8'h01, 8'h01},
        '{8'h01, 8'h02, 8'h03, 8'h01},
        '{8'h01, 8'h01, 8'h02, 8'h03},
        '{8'h03, 8'h01, 8'h01, 8'h02}
    };

    localparam logic [7:0] MC_INV [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Only the constants that appear in the two matrices are supported;
    // anything else yields zero.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h01:   return x;
            8'h02:   return x2;
            8'h03:   return x2 ^ x;
            8'h09:   return x8 ^ x;
            8'h0b:   return x8 ^ x2 ^ x;
            8'h0d:   return x8 ^ x4 ^ x;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_gf_col_mul.sv
// Multiplies one incoming column byte by the four coefficients of its
// matrix column, giving that byte's contribution to every output byte.
module aes_gf_col_mul
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [1:0] idx_i,
    input  logic       inv_i,
    output aes_col_t   prod_o
);

    // prod_o[j] = M[j][idx] * data for the selected direction
    always_comb begin
        prod_o = '0;
        for (int j = 0; j < 4; j++) begin
            prod_o[j] = gf_mul(data_i, inv_i ? MC_INV[j][idx_i] : MC_FWD[j][idx_i]);
        end
    end

endmodule

// File: rtl/aes_mix_columns_serial.sv
// Byte-serial MixColumns / InvMixColumns engine. Bytes of a column arrive
// one per cycle and are folded into four accumulators; the finished column
// is parked in an output register. Only the 4th byte of a following column
// has to wait for a stalled output.
module aes_mix_columns_serial
    import aes_pkg::*;
#(
    parameter bit INV_EN    = 1'b1,
    parameter bit BYPASS_EN = 1'b1,
    parameter int TAG_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             mode_inv,
    input  logic             bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_col,
    output logic [TAG_W-1:0] out_tag
);

    logic [1:0]       cnt_q, cnt_d;
    logic             inv_q, inv_d;
    logic             byp_q, byp_d;
    aes_col_t         acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_col_q, out_col_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic     accept;
    logic     first;
    logic     inv_eff;
    logic     byp_eff;
    aes_col_t prod;
    aes_col_t col_nxt;

    // Byte 0 takes the mode straight from the pins so its own product uses it.
    assign first   = (cnt_q == 2'd0);
    assign inv_eff = first ? (INV_EN && mode_inv) : inv_q;
    assign byp_eff = first ? (BYPASS_EN && bypass) : byp_q;

    assign in_ready = !((cnt_q == 2'd3) && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    aes_gf_col_mul u_mul (
        .data_i (in_byte),
        .idx_i  (cnt_q),
        .inv_i  (inv_eff),
        .prod_o (prod)
    );

    // Next accumulator values including the current byte; byte 0 restarts the sums.
    always_comb begin
        col_nxt = '0;
        for (int j = 0; j < 4; j++) begin
            col_nxt[j] = (first ? 8'h00 : acc_q[j])
                       ^ (byp_eff ? ((2'(j) == cnt_q) ? in_byte : 8'h00) : prod[j]);
        end
    end

    // Next-state for counter, mode latch, accumulators and output register.
    always_comb begin
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        byp_d       = byp_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        out_tag_d   = out_tag_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            cnt_d = cnt_q + 2'd1;
            acc_d = col_nxt;
            if (first) begin
                inv_d = inv_eff;
                byp_d = byp_eff;
            end
            // A load on the same cycle as a drain keeps out_valid high.
            if (cnt_q == 2'd3) begin
                out_col_d   = {col_nxt[0], col_nxt[1], col_nxt[2], col_nxt[3]};
                out_tag_d   = in_tag;
                out_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset drops any partial column and pending output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            inv_q       <= 1'b0;
            byp_q       <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            byp_q       <= byp_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_aes_mix_columns_serial.sv
// Directed and randomized bench for the byte-serial MixColumns engine.
module tb_aes_mix_columns_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic [1:0]  in_tag;
    logic        mode_inv;
    logic        bypass;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_col;
    logic [1:0]  out_tag;

    int total = 0;
    int bad   = 0;
    int waited;
    int maxwait;

    aes_mix_columns_serial #(.INV_EN(1'b1), .BYPASS_EN(1'b1), .TAG_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_tag    (in_tag),
        .mode_inv  (mode_inv),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Plain shift-and-add multiplication in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference column transform: b_j = XOR_i c[(i-j) mod 4] * a_i (circulant matrix).
    function automatic logic [31:0] model(input logic [31:0] a, input bit inv, input bit byp);
        logic [7:0] fb [4];
        logic [7:0] ib [4];
        logic [7:0] av [4];
        logic [7:0] bv [4];
        fb = '{8'h02, 8'h03, 8'h01, 8'h01};
        ib = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int i = 0; i < 4; i++) av[i] = a[31-8*i -: 8];
        if (byp) return a;
        for (int j = 0; j < 4; j++) begin
            bv[j] = 8'h00;
            for (int i = 0; i < 4; i++)
                bv[j] = bv[j] ^ gmul(inv ? ib[(i-j+4)%4] : fb[(i-j+4)%4], av[i]);
        end
        return {bv[0], bv[1], bv[2], bv[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic push(input logic [7:0] b, input logic inv, input logic byp, input logic [1:0] tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_byte  = b;
        mode_inv = inv;
        bypass   = byp;
        in_tag   = tag;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (waited > maxwait) maxwait = waited;
        if (n >= 64) chk("push_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    // Tag of the first three bytes is deliberately different from the 4th.
    task automatic send_col(input logic [31:0] a, input logic inv, input logic byp, input logic [1:0] tag);
        for (int k = 0; k < 4; k++)
            push(a[31-8*k -: 8], inv, byp, (k == 3) ? tag : ~tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic        rinv;
        logic        rbyp;
        logic [1:0]  rtag;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_tag    = 2'd0;
        mode_inv  = 1'b0;
        bypass    = 1'b0;
        out_ready = 1'b1;
        maxwait   = 0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_col", out_col, 32'h0);
        chk("rst_out_tag", {30'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 forward column, latency check
        send_col(32'hd4bf5d30, 1'b0, 1'b0, 2'd1);
        chk("fips_valid", {31'd0, out_valid}, 32'd1);
        chk("fips_col", out_col, 32'h046681e5);
        chk("fips_tag", {30'd0, out_tag}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid_low", {31'd0, out_valid}, 32'd0);

        // forward then inverse round trip
        send_col(32'hdb135345, 1'b0, 1'b0, 2'd2);
        chk("fwd2_col", out_col, 32'h8e4da1bc);
        in_valid = 1'b0;
        @(negedge clk);
        send_col(32'h8e4da1bc, 1'b1, 1'b0, 2'd3);
        chk("inv2_valid", {31'd0, out_valid}, 32'd1);
        chk("inv2_col", out_col, 32'hdb135345);
        in_valid = 1'b0;
        @(negedge clk);

        // back-to-back columns, no bubbles
        maxwait = 0;
        send_col(32'hf20a225c, 1'b0, 1'b0, 2'd0);
        chk("b2b_col1", out_col, 32'h9fdc589d);
        send_col(32'hc6c6c6c6, 1'b0, 1'b0, 2'd1);
        chk("b2b_col2", out_col, 32'hc6c6c6c6);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_no_stall", maxwait, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // backpressure: bytes 0..2 go in, 4th waits, same-cycle drain and load
        out_ready = 1'b0;
        send_col(32'hd4bf5d30, 1'b0, 1'b0, 2'd2);
        chk("bp_col_a", out_col, 32'h046681e5);
        maxwait = 0;
        push(8'hdb, 1'b0, 1'b0, 2'd0);
        push(8'h13, 1'b0, 1'b0, 2'd0);
        push(8'h53, 1'b0, 1'b0, 2'd0);
        chk("bp_first3_no_wait", maxwait, 32'd0);
        in_valid = 1'b1;
        in_byte  = 8'h45;
        in_tag   = 2'd3;
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_hold_col", out_col, 32'h046681e5);
        chk("bp_hold_tag", {30'd0, out_tag}, 32'd2);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_still_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_up", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_reload_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_reload_col", out_col, 32'h8e4da1bc);
        chk("bp_reload_tag", {30'd0, out_tag}, 32'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // bypass with tag from 4th byte
        send_col(32'h01020304, 1'b0, 1'b1, 2'd2);
        chk("byp_col", out_col, 32'h01020304);
        chk("byp_tag", {30'd0, out_tag}, 32'd2);

        // mode pins ignored after byte 0
        push(8'hd4, 1'b0, 1'b0, 2'd0);
        push(8'hbf, 1'b1, 1'b1, 2'd0);
        push(8'h5d, 1'b1, 1'b1, 2'd0);
        push(8'h30, 1'b1, 1'b1, 2'd1);
        chk("midmode_col", out_col, 32'h046681e5);
        in_valid = 1'b0;
        @(negedge clk);

        // reset mid-column with a pending output
        out_ready = 1'b0;
        send_col(32'hdb135345, 1'b0, 1'b0, 2'd3);
        push(8'h11, 1'b0, 1'b0, 2'd0);
        push(8'h22, 1'b0, 1'b0, 2'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_col", out_col, 32'h0);
        chk("midrst_tag", {30'd0, out_tag}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send_col(32'hd4bf5d30, 1'b0, 1'b0, 2'd1);
        chk("postrst_col", out_col, 32'h046681e5);
        in_valid = 1'b0;
        @(negedge clk);

        // randomized columns against the reference model
        for (int n = 0; n < 40; n++) begin
            ra   = $urandom;
            rinv = 1'($urandom_range(0, 1));
            rbyp = ($urandom_range(0, 3) == 0);
            rtag = 2'($urandom_range(0, 3));
            send_col(ra, rinv, rbyp, rtag);
            chk("rand_valid", {31'd0, out_valid}, 32'd1);
            chk("rand_col", out_col, model(ra, rinv, rbyp));
            chk("rand_tag", {30'd0, out_tag}, {30'd0, rtag});
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
